// File: rtl/sim_pkg.sv
// Shared state encoding, default phase lengths and helpers for the simulation
// run controller.
package sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        RST,
        RUN,
        END,
        TMO
    } sim_state_e;

    localparam int unsigned DEF_PRE_CYCLES     = 10;
    localparam int unsigned DEF_RST_CYCLES     = 10;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 5000000;

    // Phase down-counter width; PRE/RST lengths are limited to 16 bits.
    localparam int PHASE_W = 16;

    function automatic int hart_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sim_end_arbiter.sv
// Combinational end-of-program arbiter: lowest-index hart with valid&end wins.
// Also reports how many harts retire this cycle.
module sim_end_arbiter
    import sim_pkg::*;
#(
    parameter int NUM_HARTS = 1,
    parameter int CODE_W    = 32,
    localparam int HART_W   = hart_idx_w(NUM_HARTS),
    localparam int POP_W    = $clog2(NUM_HARTS + 1)
) (
    input  logic [NUM_HARTS-1:0]        valid_i,
    input  logic [NUM_HARTS-1:0]        end_i,
    input  logic [NUM_HARTS*CODE_W-1:0] code_i,
    output logic                        any_end_o,
    output logic [HART_W-1:0]           end_idx_o,
    output logic [CODE_W-1:0]           end_code_o,
    output logic [POP_W-1:0]            pop_o
);

    // Scan from the top so the last assignment is the lowest ending hart.
    always_comb begin
        any_end_o  = 1'b0;
        end_idx_o  = '0;
        end_code_o = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (valid_i[h] && end_i[h]) begin
                any_end_o  = 1'b1;
                end_idx_o  = HART_W'(h);
                end_code_o = code_i[h*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        pop_o = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            pop_o = pop_o + POP_W'(valid_i[h]);
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences the NPC reset, watches retirements for
// the program end or a timeout, and keeps saturating cycle/instret counters.
module sim_run_ctrl
    import sim_pkg::*;
#(
    parameter int unsigned PRE_CYCLES     = DEF_PRE_CYCLES,
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int          NUM_HARTS      = 1,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          CNT_W          = 64,
    parameter int          CODE_W         = 32,
    localparam int         HART_W         = hart_idx_w(NUM_HARTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_HARTS-1:0]        retire_valid,
    input  logic [NUM_HARTS-1:0]        retire_end,
    input  logic [NUM_HARTS*CODE_W-1:0] retire_code,
    output logic                        dut_reset,
    output logic                        running,
    output logic                        done,
    output logic                        pass,
    output logic                        timed_out,
    output logic [CODE_W-1:0]           exit_code,
    output logic [HART_W-1:0]           end_hart,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [CNT_W-1:0]            instret_count
);

    localparam int                 POP_W    = $clog2(NUM_HARTS + 1);
    localparam int                 CW1      = CNT_W + 1;
    localparam logic [PHASE_W-1:0] PRE_LOAD = PHASE_W'(PRE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RST_LOAD = PHASE_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                 TMO_EN   = (TIMEOUT_CYCLES != 0);

    sim_state_e          state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                dut_reset_q, dut_reset_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timed_out_q, timed_out_d;
    logic [CODE_W-1:0]   exit_code_q, exit_code_d;
    logic [HART_W-1:0]   end_hart_q, end_hart_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instret_q, instret_d;

    logic                any_end;
    logic [HART_W-1:0]   end_idx;
    logic [CODE_W-1:0]   end_code;
    logic [POP_W-1:0]    pop_cnt;
    logic [CNT_W:0]      cyc_sum, ins_sum;

    sim_end_arbiter #(
        .NUM_HARTS (NUM_HARTS),
        .CODE_W    (CODE_W)
    ) u_arb (
        .valid_i    (retire_valid),
        .end_i      (retire_end),
        .code_i     (retire_code),
        .any_end_o  (any_end),
        .end_idx_o  (end_idx),
        .end_code_o (end_code),
        .pop_o      (pop_cnt)
    );

    // One extra bit catches the carry so the counters stick at all-ones.
    assign cyc_sum = {1'b0, cycle_q} + CW1'(1);
    assign ins_sum = {1'b0, instret_q} + CW1'(pop_cnt);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        exit_code_d = exit_code_q;
        end_hart_d  = end_hart_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PRE;
                    phase_d     = PRE_LOAD;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timed_out_d = 1'b0;
                    exit_code_d = '0;
                    end_hart_d  = '0;
                    cycle_d     = '0;
                    instret_d   = '0;
                end
            end
            PRE: begin
                if (phase_q == '0) begin
                    state_d = RST;
                    phase_d = RST_LOAD;
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
            RST: begin
                if (phase_q == '0) begin
                    state_d = RUN;
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
            RUN: begin
                cycle_d   = cyc_sum[CNT_W] ? '1 : cyc_sum[CNT_W-1:0];
                instret_d = ins_sum[CNT_W] ? '1 : ins_sum[CNT_W-1:0];
                if (any_end) begin
                    state_d     = END;
                    done_d      = 1'b1;
                    pass_d      = (end_code == '0);
                    exit_code_d = end_code;
                    end_hart_d  = end_idx;
                end else if (TMO_EN && (cycle_q == TMO_LAST)) begin
                    state_d     = TMO;
                    timed_out_d = 1'b1;
                end
            end
            default: ;
        endcase
        // Decoded from the next state so the registered outputs line up with it.
        dut_reset_d = (state_d == RST);
        running_d   = (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            dut_reset_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            exit_code_q <= '0;
            end_hart_q  <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dut_reset_q <= dut_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            exit_code_q <= exit_code_d;
            end_hart_q  <= end_hart_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
        end
    end

    assign dut_reset     = dut_reset_q;
    assign running       = running_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timed_out     = timed_out_q;
    assign exit_code     = exit_code_q;
    assign end_hart      = end_hart_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: a default single-hart instance and a 4-hart instance
// with a 100-cycle timeout, both checked against a per-run behavioural model.
module tb_sim_run_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: all defaults, one hart
    logic        a_reset = 1'b0, a_start = 1'b0;
    logic [0:0]  a_valid = '0, a_end = '0;
    logic [31:0] a_code  = '0;
    logic        a_dut_reset, a_running, a_done, a_pass, a_timed_out;
    logic [31:0] a_exit_code;
    logic [0:0]  a_end_hart;
    logic [63:0] a_cycle_count, a_instret_count;

    sim_run_ctrl u_a (
        .clock         (clock),
        .reset         (a_reset),
        .start         (a_start),
        .retire_valid  (a_valid),
        .retire_end    (a_end),
        .retire_code   (a_code),
        .dut_reset     (a_dut_reset),
        .running       (a_running),
        .done          (a_done),
        .pass          (a_pass),
        .timed_out     (a_timed_out),
        .exit_code     (a_exit_code),
        .end_hart      (a_end_hart),
        .cycle_count   (a_cycle_count),
        .instret_count (a_instret_count)
    );

    // Instance B: four harts, 100-cycle timeout
    logic         b_reset = 1'b0, b_start = 1'b0;
    logic [3:0]   b_valid = '0, b_end = '0;
    logic [127:0] b_code  = '0;
    logic         b_dut_reset, b_running, b_done, b_pass, b_timed_out;
    logic [31:0]  b_exit_code;
    logic [1:0]   b_end_hart;
    logic [63:0]  b_cycle_count, b_instret_count;

    sim_run_ctrl #(
        .NUM_HARTS      (4),
        .TIMEOUT_CYCLES (100)
    ) u_b (
        .clock         (clock),
        .reset         (b_reset),
        .start         (b_start),
        .retire_valid  (b_valid),
        .retire_end    (b_end),
        .retire_code   (b_code),
        .dut_reset     (b_dut_reset),
        .running       (b_running),
        .done          (b_done),
        .pass          (b_pass),
        .timed_out     (b_timed_out),
        .exit_code     (b_exit_code),
        .end_hart      (b_end_hart),
        .cycle_count   (b_cycle_count),
        .instret_count (b_instret_count)
    );

    always @(negedge clock) begin
        if (b_running === 1'b1)
            assert (!$isunknown({b_valid, b_end})) else $error("unknown retire input on B in RUN");
        if (a_running === 1'b1)
            assert (!$isunknown({a_valid, a_end})) else $error("unknown retire input on A in RUN");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1'b0;
        b_reset = 1'b0;
        repeat (3) tick();
        a_reset = 1'b1;
        b_reset = 1'b1;
        tick();
        n_checks++;
        if ({a_dut_reset, a_running, a_done, a_pass, a_timed_out, a_exit_code, a_end_hart,
             a_cycle_count, a_instret_count} !== '0)
            $display("FAIL reset_a: got flags %b exit %h cyc %0d ins %0d, want all zero",
                     {a_dut_reset, a_running, a_done, a_pass, a_timed_out}, a_exit_code,
                     a_cycle_count, a_instret_count);
        else n_pass++;
        n_checks++;
        if ({b_dut_reset, b_running, b_done, b_pass, b_timed_out, b_exit_code, b_end_hart,
             b_cycle_count, b_instret_count} !== '0)
            $display("FAIL reset_b: got flags %b exit %h cyc %0d ins %0d, want all zero",
                     {b_dut_reset, b_running, b_done, b_pass, b_timed_out}, b_exit_code,
                     b_cycle_count, b_instret_count);
        else n_pass++;
    endtask

    // Pulses start on B and checks 10 cycles low, 10 high, then running; returns in RUN.
    task automatic b_start_seq(input string tag);
        logic [1:0] exp_seq;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            exp_seq[1] = (i >= 10) && (i < 20);
            exp_seq[0] = (i == 20);
            n_checks++;
            if ({b_dut_reset, b_running} !== exp_seq)
                $display("FAIL %s seq[%0d]: dut_reset,running got %b want %b",
                         tag, i, {b_dut_reset, b_running}, exp_seq);
            else n_pass++;
            if (i < 20) tick();
        end
    endtask

    task automatic a_run(input logic [31:0] code, input string tag);
        int cyc = 0;
        int r = 0;
        logic v, e;
        logic [1:0] exp_seq;
        logic [4:0] exp_flags;
        a_reset = 1'b0;
        tick();
        a_reset = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            exp_seq[1] = (i >= 10) && (i < 20);
            exp_seq[0] = (i == 20);
            n_checks++;
            if ({a_dut_reset, a_running} !== exp_seq)
                $display("FAIL %s seq[%0d]: dut_reset,running got %b want %b",
                         tag, i, {a_dut_reset, a_running}, exp_seq);
            else n_pass++;
            if (i < 20) tick();
        end
        // Five retirements with random idle gaps; the fifth carries end.
        while (r < 5 && cyc < 200) begin
            cyc++;
            v = ($urandom_range(2) != 0);
            e = v ? (r == 4) : 1'($urandom);
            a_valid = v;
            a_end   = e;
            a_code  = (v && e) ? code : $urandom;
            tick();
            if (v) r++;
        end
        a_valid = '0;
        a_end   = '0;
        exp_flags = {1'b1, (code == 32'd0), 1'b0, 1'b0, 1'b0};
        for (int f = 0; f < 2; f++) begin
            n_checks++;
            if ({a_done, a_pass, a_timed_out, a_running, a_dut_reset} !== exp_flags)
                $display("FAIL %s flags[%0d]: done,pass,tmo,run,rst got %b want %b",
                         tag, f, {a_done, a_pass, a_timed_out, a_running, a_dut_reset}, exp_flags);
            else n_pass++;
            n_checks++;
            if (a_exit_code !== code || a_end_hart !== 1'b0)
                $display("FAIL %s exit[%0d]: got %h/%0d want %h/0", tag, f, a_exit_code, a_end_hart, code);
            else n_pass++;
            n_checks++;
            if (a_cycle_count !== 64'(cyc) || a_instret_count !== 64'd5)
                $display("FAIL %s counts[%0d]: cyc %0d ins %0d want %0d 5",
                         tag, f, a_cycle_count, a_instret_count, cyc);
            else n_pass++;
            // Second pass: the results must survive retirements and start pulses.
            if (f == 0) begin
                repeat (5) begin
                    a_valid = 1'b1;
                    a_end   = 1'($urandom);
                    a_code  = $urandom;
                    a_start = 1'($urandom);
                    tick();
                end
                a_valid = '0;
                a_end   = '0;
                a_start = 1'b0;
            end
        end
    endtask

    task automatic b_run(input int end_at, input bit fixed, input logic [3:0] fv,
                         input logic [3:0] fe, input logic [127:0] fc, input string tag);
        int cyc = 0;
        int k;
        longint unsigned ins = 0;
        bit ended = 1'b0, tmo = 1'b0;
        logic [31:0]  xcode = '0;
        logic [1:0]   xhart = '0;
        logic [3:0]   v, e, hit;
        logic [127:0] c;
        logic [4:0]   exp_flags;
        b_reset = 1'b0;
        tick();
        b_reset = 1'b1;
        b_start_seq(tag);
        while (!ended && !tmo && cyc < 300) begin
            cyc++;
            for (int h = 0; h < 4; h++)
                c[h*32 +: 32] = ($urandom_range(1) == 0) ? 32'd0 : $urandom;
            v = 4'($urandom);
            e = 4'($urandom) & ~v;
            if (cyc == end_at) begin
                if (fixed) begin
                    v = fv;
                    e = fe;
                    c = fc;
                end else begin
                    k = $urandom_range(3);
                    v[k] = 1'b1;
                    e = 4'($urandom) | (4'b0001 << k);
                end
            end
            b_valid = v;
            b_end   = e;
            b_code  = c;
            tick();
            ins += longint'($countones(v));
            hit = v & e;
            if (hit != 4'b0) begin
                ended = 1'b1;
                for (int h = 0; h < 4; h++) begin
                    if (hit[h]) begin
                        xhart = 2'(h);
                        xcode = c[h*32 +: 32];
                        break;
                    end
                end
            end else if (cyc == 100) begin
                tmo = 1'b1;
            end
        end
        b_valid = '0;
        b_end   = '0;
        exp_flags = {ended, ended && (xcode == 32'd0), tmo, 1'b0, 1'b0};
        for (int f = 0; f < 2; f++) begin
            n_checks++;
            if ({b_done, b_pass, b_timed_out, b_running, b_dut_reset} !== exp_flags)
                $display("FAIL %s flags[%0d]: done,pass,tmo,run,rst got %b want %b",
                         tag, f, {b_done, b_pass, b_timed_out, b_running, b_dut_reset}, exp_flags);
            else n_pass++;
            n_checks++;
            if (b_exit_code !== xcode || b_end_hart !== xhart)
                $display("FAIL %s exit[%0d]: code/hart got %h/%0d want %h/%0d",
                         tag, f, b_exit_code, b_end_hart, xcode, xhart);
            else n_pass++;
            n_checks++;
            if (b_cycle_count !== 64'(cyc) || b_instret_count !== ins)
                $display("FAIL %s counts[%0d]: cyc %0d ins %0d want %0d %0d",
                         tag, f, b_cycle_count, b_instret_count, cyc, ins);
            else n_pass++;
            if (f == 0) begin
                repeat (5) begin
                    b_valid = 4'($urandom);
                    b_end   = 4'b1111;
                    b_code  = {$urandom, $urandom, $urandom, $urandom};
                    b_start = 1'($urandom);
                    tick();
                end
                b_valid = '0;
                b_end   = '0;
                b_start = 1'b0;
            end
        end
    endtask

    task automatic test_defaults();
        a_run(32'd0, "a_pass");
        a_run(32'h2A, "a_fail");
        a_run($urandom, "a_rand");
    endtask

    task automatic test_multi_end();
        b_run(3, 1'b1, 4'b1111, 4'b1010, {32'd9, 32'h1234, 32'd7, 32'hABCD}, "multi_same");
        b_run(5, 1'b1, 4'b1101, 4'b1100, {32'd0, 32'd5, 32'd3, 32'd1}, "multi_hi");
    endtask

    task automatic test_timeout();
        b_run(0, 1'b0, '0, '0, '0, "timeout");
        b_run(100, 1'b0, '0, '0, '0, "end_at_limit");
    endtask

    task automatic test_reset_mid();
        b_reset = 1'b0;
        tick();
        b_reset = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (b_dut_reset !== 1'b1)
            $display("FAIL mid_rst_phase: dut_reset got %b want 1", b_dut_reset);
        else n_pass++;
        b_reset = 1'b0;
        tick();
        n_checks++;
        if ({b_dut_reset, b_running} !== 2'b00)
            $display("FAIL mid_rst_drop: dut_reset,running got %b want 00", {b_dut_reset, b_running});
        else n_pass++;
        b_reset = 1'b1;
        tick();
        b_start_seq("replay1");
        repeat (7) begin
            b_valid = 4'($urandom);
            b_end   = '0;
            tick();
        end
        b_valid = '0;
        b_reset = 1'b0;
        tick();
        b_reset = 1'b1;
        n_checks++;
        if ({b_dut_reset, b_running, b_done, b_pass, b_timed_out, b_exit_code, b_end_hart,
             b_cycle_count, b_instret_count} !== '0)
            $display("FAIL mid_run_reset: flags %b cyc %0d ins %0d, want all zero",
                     {b_dut_reset, b_running, b_done, b_pass, b_timed_out},
                     b_cycle_count, b_instret_count);
        else n_pass++;
        b_start_seq("replay2");
        b_reset = 1'b0;
        tick();
        b_reset = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            b_run($urandom_range(120, 1), 1'b0, '0, '0, '0, "random");
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_multi_end();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Synthesizable run controller for the NPC simulation top.
- Owns the DUT reset sequence, the run window, the end-of-program and timeout checks, and the performance counters.
- Generalised to NUM_HARTS write-back retire channels.
- Lets the bench shell become a thin clock-plus-preload wrapper that polls done/pass/timed_out.

Parameters:
- PRE_CYCLES, 10: cycles held in PRE before the DUT reset is asserted (1..2^16-1).
- RST_CYCLES, 10: cycles the DUT reset is held asserted (1..2^16-1).
- NUM_HARTS, 1: number of retire channels (1..8).
- TIMEOUT_CYCLES, 5000000: RUN-cycle budget; 0 disables the timeout.
- CNT_W, 64: width of cycle_count and instret_count.
- CODE_W, 32: exit-code width (a0 at ebreak).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset of this block.
- start  in  1  one-cycle pulse that begins a run; sampled only in IDLE.
- retire_valid  in  NUM_HARTS  per-hart WBU io_out_valid.
- retire_end  in  NUM_HARTS  per-hart WBU io_out_bits_isEnd.
- retire_code  in  NUM_HARTS*CODE_W  per-hart exit code; hart h occupies bits [h*CODE_W +: CODE_W].
- dut_reset  out  1  active-high reset driven to NPC.
- running  out  1  high in RUN.
- done  out  1  sticky; run ended by program end.
- pass  out  1  valid when done; 1 iff exit_code == 0.
- timed_out  out  1  sticky; run ended by timeout.
- exit_code  out  CODE_W  code captured at end.
- end_hart  out  max(1,$clog2(NUM_HARTS))  index of the hart that ended the run.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- instret_count  out  CNT_W  retirements counted in RUN.

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-low: state is cleared at a clock edge where reset==0.
- Reset values: state=IDLE; dut_reset=0; running, done, pass, timed_out = 0; exit_code, end_hart, cycle_count, instret_count = 0.
- Reset mid-run: synchronous reset low in any state returns to IDLE with all reset values on the next edge, including dropping dut_reset.
- FSM states: IDLE, PRE, RST, RUN, END, TMO.
- IDLE: dut_reset=0. start=1 -> PRE; clears both counters and the captured results.
- PRE: dut_reset=0 for exactly PRE_CYCLES cycles, then -> RST.
- RST: dut_reset=1 for exactly RST_CYCLES cycles, then -> RUN. dut_reset is a registered output, never a glitch.
- RUN: dut_reset=0, running=1.
  - Each cycle, cycle_count increments by 1 (saturates at all-ones).
  - Each cycle, instret_count increments by popcount(retire_valid) (saturating).
- End detection: hart h ends the run when retire_valid[h] & retire_end[h].
  - Several harts ending in the same cycle: the lowest index wins; its code goes to exit_code and its index to end_hart.
  - The ending retirement is itself counted in instret_count, and that cycle is counted in cycle_count.
  - Next state: END, with done=1 and pass=(captured code==0).
- Timeout: with TIMEOUT_CYCLES!=0, when cycle_count reaches TIMEOUT_CYCLES-1 and no end is detected that cycle -> TMO, timed_out=1.
  - End and timeout in the same cycle: end wins.
- END and TMO are terminal until reset.
  - Counters and results are frozen; start and retire inputs are ignored.
  - dut_reset=0, running=0.
- Outside RUN, the retire_* inputs have no effect.
- An X or Z on retire_valid or retire_end while in RUN is not filtered; the bench asserts against it.

Decomposition:
- Package sim_pkg:
  - state enum typedef (IDLE, PRE, RST, RUN, END, TMO).
  - hart-index width function.
  - default constants for PRE_CYCLES, RST_CYCLES and TIMEOUT_CYCLES.
- One sub-module, sim_end_arbiter: combinational lowest-index priority select over NUM_HARTS.
  - Outputs any_end, end_idx, end_code.
  - Also outputs popcount(retire_valid).
- Phase down-counter, the CNT_W counters and result registers are in sim_run_ctrl.

Test Plan:
- Defaults, NUM_HARTS=1:
  - reset low 3 cycles, then high; start pulse.
  - dut_reset is 0 for 10 cycles, 1 for exactly 10 cycles, then 0.
  - running rises the cycle dut_reset falls.
- Program end: 5 retirements, the 5th with end=1 and code=0.
  - done=1, pass=1, exit_code=0, instret_count=5.
  - cycle_count equals RUN cycles including the end cycle; values frozen afterward.
- Failing end: code=0x2A -> done=1, pass=0, exit_code=0x2A.
- NUM_HARTS=4, same cycle:
  - retire_valid=4'b1111, retire_end=4'b1010, codes h1=7, h3=9.
  - Required: end_hart=1, exit_code=7, instret_count increments by 4 that cycle.
- Timeout, TIMEOUT_CYCLES=100:
  - With no end: timed_out=1 and cycle_count=100; done stays 0.
  - Separate run with end on cycle 100: done=1, timed_out=0.
- Reset mid-operation:
  - reset low during RST: dut_reset=0 and state IDLE next edge.
  - reset low during RUN: all outputs 0; a following start replays the full 10+10 sequence.
  - start pulsed in END is ignored.
